// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 tables, shift schedules, FSM states
// and the small permutation/rotation helpers shared by the schedule blocks.
package des_pkg;

  localparam int KEY_W = 64;
  localparam int CD_W  = 56;
  localparam int RK_W  = 48;
  localparam int HALF_W = 28;

  // Entries are DES bit numbers (1 = MSB of the source word).
  localparam logic [7:0] PC1_TBL [0:CD_W-1] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam logic [7:0] PC2_TBL [0:RK_W-1] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  // Encrypt: left rotations. Decrypt: right rotations walking K16 back to K1
  // (entry 0 is zero because C16||D16 equals the PC-1 output).
  localparam logic [1:0] ENC_SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] DEC_SHIFT [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    case (n)
      2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
      2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[HALF_W-1:1]};
      2'd2:    return {x[1:0], x[HALF_W-1:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [RK_W-1:0] k;
    for (int j = 0; j < RK_W; j++)
      k[RK_W-1-j] = cd[CD_W - int'(PC2_TBL[j])];
    return k;
  endfunction

  // DES wants odd parity per byte; any even-parity byte flags the key.
  function automatic logic key_parity_err(input logic [KEY_W-1:0] k);
    logic err;
    err = 1'b0;
    for (int b = 0; b < 8; b++)
      if (^k[b*8 +: 8] == 1'b0) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/des_pc1.sv
// PC-1: drops the eight parity bits and permutes the key into C||D.
module des_pc1
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic [CD_W-1:0]  cd
);

  for (genvar j = 0; j < CD_W; j++) begin : g_bit
    assign cd[CD_W-1-j] = key[KEY_W - int'(PC1_TBL[j])];
  end

  // Parity bits are intentionally not part of the permutation.
  logic [7:0] par_bits;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign par_bits[b] = key[b*8];
  end
  logic unused_par;
  assign unused_par = ^par_bits;

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: one PC-2 subkey per consumer handshake,
// forward (K1..K16) for encrypt, reverse (K16..K1) for decrypt.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int ROUNDS       = 16,
  parameter bit PARITY_CHECK = 1'b1
)(
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic              i_Mode,
  input  logic [KEY_W-1:0]  i_Key,
  input  logic              i_Abort,
  input  logic              i_Key_Ready,
  output logic              o_Busy,
  output logic              o_Key_Valid,
  output logic [RK_W-1:0]   o_Round_Key,
  output logic [3:0]        o_Round,
  output logic              o_Done,
  output logic              o_Parity_Err
);

  state_t              state;
  logic [HALF_W-1:0]   c_q, d_q;
  logic [3:0]          round_q;
  logic                mode_q, busy_q, valid_q, done_q, perr_q;

  logic [CD_W-1:0]     cd_load;
  logic [HALF_W-1:0]   c_ld, d_ld, c_nx, d_nx;
  logic [3:0]          nxt_idx;
  logic                start_perr;

  des_pc1 u_pc1 (.key(i_Key), .cd(cd_load));

  assign start_perr = PARITY_CHECK ? key_parity_err(i_Key) : 1'b0;

  // Load value (round-0 rotation folded in) and next-round rotation.
  always_comb begin
    nxt_idx = round_q + 4'd1;
    if (i_Mode) begin
      c_ld = rotr28(cd_load[CD_W-1:HALF_W], DEC_SHIFT[0]);
      d_ld = rotr28(cd_load[HALF_W-1:0],    DEC_SHIFT[0]);
    end else begin
      c_ld = rotl28(cd_load[CD_W-1:HALF_W], ENC_SHIFT[0]);
      d_ld = rotl28(cd_load[HALF_W-1:0],    ENC_SHIFT[0]);
    end
    if (mode_q) begin
      c_nx = rotr28(c_q, DEC_SHIFT[nxt_idx]);
      d_nx = rotr28(d_q, DEC_SHIFT[nxt_idx]);
    end else begin
      c_nx = rotl28(c_q, ENC_SHIFT[nxt_idx]);
      d_nx = rotl28(d_q, ENC_SHIFT[nxt_idx]);
    end
  end

  // Control FSM; abort outranks both start and handshake.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start && !i_Abort) begin
            c_q     <= c_ld;
            d_q     <= d_ld;
            round_q <= '0;
            mode_q  <= i_Mode;
            perr_q  <= start_perr;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (i_Abort) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            state   <= IDLE;
          end else if (i_Key_Ready) begin
            if (round_q == 4'(ROUNDS-1)) begin
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              round_q <= nxt_idx;
              c_q     <= c_nx;
              d_q     <= d_nx;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Busy       = busy_q;
  assign o_Key_Valid  = valid_q;
  assign o_Round      = round_q;
  assign o_Done       = done_q;
  assign o_Parity_Err = perr_q;
  assign o_Round_Key  = pc2({c_q, d_q});

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule using the classic 133457799BBCDFF1
// key-schedule example vectors.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_start4, i_mode, i_abort, i_key_ready;
  logic [63:0] i_key;

  logic        o_busy, o_key_valid, o_done, o_parity_err;
  logic [47:0] o_round_key;
  logic [3:0]  o_round;

  logic        o4_busy, o4_key_valid, o4_done, o4_parity_err;
  logic [47:0] o4_round_key;
  logic [3:0]  o4_round;

  always #5 clk = ~clk;

  des_key_schedule #(.ROUNDS(16), .PARITY_CHECK(1'b1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_start), .i_Mode(i_mode), .i_Key(i_key),
    .i_Abort(i_abort), .i_Key_Ready(i_key_ready), .o_Busy(o_busy),
    .o_Key_Valid(o_key_valid), .o_Round_Key(o_round_key), .o_Round(o_round),
    .o_Done(o_done), .o_Parity_Err(o_parity_err));

  des_key_schedule #(.ROUNDS(4), .PARITY_CHECK(1'b1)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_start4), .i_Mode(i_mode), .i_Key(i_key),
    .i_Abort(i_abort), .i_Key_Ready(i_key_ready), .o_Busy(o4_busy),
    .o_Key_Valid(o4_key_valid), .o_Round_Key(o4_round_key), .o_Round(o4_round),
    .o_Done(o4_done), .o_Parity_Err(o4_parity_err));

  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BADP = 64'h123457799BBCDFF1;

  // K1..K16 for KEY_GOOD (also for KEY_BADP: only a parity bit differs).
  localparam logic [47:0] EK [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct {
    logic [3:0]  round;
    logic [47:0] key;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Monitor: every valid cycle must show the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && o_key_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_key", {16'h0, o_round_key}, 64'h0);
      end else begin
        chk("round_idx", 64'(o_round), 64'(sb[0].round));
        chk("round_key", 64'(o_round_key), 64'(sb[0].key));
        if (i_key_ready && !i_abort) void'(sb.pop_front());
      end
    end
  end

  // Issue a start and queue the expected emission order.
  task automatic go(input logic [63:0] key, input logic mode);
    i_key = key; i_mode = mode; i_start = 1'b1;
    for (int r = 0; r < 16; r++) begin
      exp_t e;
      e.round = 4'(r);
      e.key   = mode ? EK[15-r] : EK[r];
      sb.push_back(e);
    end
    tick;
    i_start = 1'b0;
  endtask

  // Runs until o_Done; n = cycle index (1 = first cycle after acceptance).
  task automatic run_to_done(input int stall_round, input int stall_len, output int n);
    int left;
    left = stall_len;
    n = 1;
    while (!o_done && n < 60) begin
      if (o_key_valid && int'(o_round) == stall_round && left > 0) begin
        i_key_ready = 1'b0;
        left--;
      end else begin
        i_key_ready = 1'b1;
      end
      tick;
      n++;
    end
    i_key_ready = 1'b1;
    chk("done_seen", 64'(o_done), 64'h1);
    chk("busy_in_done", 64'(o_busy), 64'h0);
    chk("valid_in_done", 64'(o_key_valid), 64'h0);
    tick;
    chk("done_one_cycle", 64'(o_done), 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; i_start = 1'b0; i_start4 = 1'b0; i_mode = 1'b0;
    i_abort = 1'b0; i_key_ready = 1'b1; i_key = KEY_GOOD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_valid", 64'(o_key_valid), 64'h0);
    chk("rst_key", 64'(o_round_key), 64'h0);
    chk("rst_round", 64'(o_round), 64'h0);
    chk("rst_done", 64'(o_done), 64'h0);
    chk("rst_perr", 64'(o_parity_err), 64'h0);
    rst = 1'b0;
    tick;

    // Encrypt, full speed.
    go(KEY_GOOD, 1'b0);
    chk("enc_busy", 64'(o_busy), 64'h1);
    chk("enc_perr", 64'(o_parity_err), 64'h0);
    run_to_done(-1, 0, n);
    chk("enc_latency", 64'(n), 64'd17);
    tick;

    // Decrypt, full speed: reverse order.
    go(KEY_GOOD, 1'b1);
    run_to_done(-1, 0, n);
    chk("dec_latency", 64'(n), 64'd17);
    tick;

    // Backpressure at round 3 for 5 cycles.
    go(KEY_GOOD, 1'b0);
    run_to_done(3, 5, n);
    chk("stall_latency", 64'(n), 64'd22);
    tick;

    // Parity error flagged but keys still produced; cleared by next start.
    go(KEY_BADP, 1'b0);
    chk("perr_set", 64'(o_parity_err), 64'h1);
    run_to_done(-1, 0, n);
    chk("perr_sticky", 64'(o_parity_err), 64'h1);
    tick;
    go(KEY_GOOD, 1'b1);
    chk("perr_clear", 64'(o_parity_err), 64'h0);
    run_to_done(-1, 0, n);
    tick;

    // Start while busy is ignored; abort at round 7 with a handshake.
    go(KEY_GOOD, 1'b0);
    tick; tick;
    i_start = 1'b1; i_key = 64'hFFFF_FFFF_FFFF_FFFF; i_mode = 1'b1;
    tick;
    i_start = 1'b0; i_key = KEY_GOOD; i_mode = 1'b0;
    for (int k = 0; k < 20 && o_round != 4'd7; k++) tick;
    chk("abort_at_r7", 64'(o_round), 64'd7);
    i_abort = 1'b1; i_key_ready = 1'b1;
    tick;
    i_abort = 1'b0;
    sb.delete();
    chk("abort_valid", 64'(o_key_valid), 64'h0);
    chk("abort_busy", 64'(o_busy), 64'h0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_done", 64'(o_done), 64'h0);
      tick;
    end

    // Abort outranks start in IDLE.
    i_start = 1'b1; i_abort = 1'b1;
    tick;
    i_start = 1'b0; i_abort = 1'b0;
    chk("idle_abort_busy", 64'(o_busy), 64'h0);
    chk("idle_abort_valid", 64'(o_key_valid), 64'h0);
    tick;

    // Asynchronous reset mid-run.
    go(KEY_BADP, 1'b0);
    repeat (4) tick;
    chk("pre_rst_perr", 64'(o_parity_err), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(o_busy), 64'h0);
    chk("arst_valid", 64'(o_key_valid), 64'h0);
    chk("arst_key", 64'(o_round_key), 64'h0);
    chk("arst_round", 64'(o_round), 64'h0);
    chk("arst_done", 64'(o_done), 64'h0);
    chk("arst_perr", 64'(o_parity_err), 64'h0);
    sb.delete();
    tick;
    rst = 1'b0;
    tick;

    // Reduced-round build: K1..K4 then done.
    i_key = KEY_GOOD; i_mode = 1'b0; i_start4 = 1'b1;
    tick;
    i_start4 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk("r4_valid", 64'(o4_key_valid), 64'h1);
      chk("r4_round", 64'(o4_round), 64'(r));
      chk("r4_key", 64'(o4_round_key), 64'(EK[r]));
      tick;
    end
    chk("r4_done", 64'(o4_done), 64'h1);
    chk("r4_busy", 64'(o4_busy), 64'h0);
    chk("r4_main_idle", 64'(o_busy), 64'h0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES/3DES-ready round-key generator. Takes a 64-bit key, applies PC-1, then produces one 48-bit round subkey per accepted handshake.
- Encrypt mode uses left rotations; decrypt mode uses reverse-order right rotations.
- Sits between the key register and the DES round datapath, feeding one subkey per round.
- Adds a reduced-round parameter and key parity checking.

Parameters:
ROUNDS, 16, number of subkeys emitted per run (1..16); reduced values are for round-reduced test builds.
PARITY_CHECK, 1, 1 = evaluate DES odd parity on each key byte at start; 0 = o_Parity_Err tied low.

Ports:
i_Clk  input  1  system clock, rising edge.
i_Rst  input  1  asynchronous, active-high reset.
i_Start  input  1  request a new schedule; accepted only when o_Busy=0.
i_Mode  input  1  0 = encrypt (K1..K16), 1 = decrypt (K16..K1); sampled with i_Start.
i_Key  input  64  DES key; i_Key[63] = DES bit 1; parity bits (DES bits 8,16,..,64) are ignored by PC-1.
i_Abort  input  1  synchronous cancel of the current run.
i_Key_Ready  input  1  consumer accepts the current subkey.
o_Busy  output  1  high from the start acceptance until the last subkey handshake completes.
o_Key_Valid  output  1  o_Round_Key is valid.
o_Round_Key  output  48  PC-2 of the current C||D (bit 47 = PC-2 output bit 1).
o_Round  output  4  0-based index of the emitted key in emission order.
o_Done  output  1  one-cycle pulse after the final handshake.
o_Parity_Err  output  1  sticky per run; set if any key byte has even parity.

Behaviour:
- Reset (async, i_Rst=1):
  - State = IDLE; C, D, round counter and key register cleared.
  - All outputs 0.
- States:
  - IDLE: if i_Start, load C||D = PC1(i_Key), latch mode and parity result, then go to RUN.
    - If i_Start is high while busy, it is ignored.
  - RUN: o_Key_Valid=1.
    - When i_Key_Ready=1 (handshake) and o_Round = ROUNDS-1: go to DONE.
    - Otherwise on handshake: increment the round and rotate C and D by the shift for the next round.
  - DONE: o_Done=1 for one cycle, o_Busy=0 in this cycle, then IDLE.
- Shift tables (package constants):
  - Encrypt left shifts: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - The rotation for round 0 is applied during the load, so the first emitted key is K1.
  - Decrypt right shifts: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - Round 0 emits PC2(PC1(key)) = K16.
  - C and D are rotated independently, each as 28 bits.
- Latency: i_Start accepted on edge N gives o_Key_Valid=1 with o_Round=0 in cycle N+1. At most one subkey per cycle.
- Stall: while o_Key_Valid && !i_Key_Ready, o_Round_Key and o_Round hold stable.
- o_Round_Key is a registered-state PC-2. It is combinational from the C/D registers, with no added cycle.
- i_Abort:
  - In RUN: go to IDLE on the next edge, with no o_Done and o_Key_Valid dropped.
  - i_Abort has priority over a handshake in the same cycle.
  - In IDLE, i_Abort has priority over i_Start.
- o_Parity_Err:
  - Computed from i_Key at start acceptance.
  - Cleared at the next start.
  - Does not block key generation.
- Async reset mid-run: immediately returns to reset values. No o_Done.

Decomposition:
- Package des_pkg holds:
  - the PC1 table (56 entries) and PC2 table (48 entries);
  - the ENC_SHIFT and DEC_SHIFT arrays (16 x 2-bit);
  - the state enum IDLE/RUN/DONE;
  - widths KEY_W=64, CD_W=56, RK_W=48.
- One natural sub-module: des_pc1 (64→56 combinational permutation).
- PC-2 and the rotation functions live as package functions.

Test Plan:
- Encrypt: i_Key=0x133457799BBCDFF1, i_Mode=0, i_Key_Ready=1 → o_Round=0 key 0x1B02EFFC7072; o_Round=15 key 0xCB3D8B0E17F5; o_Done pulses 17 cycles after start; o_Parity_Err=0.
- Decrypt: same key, i_Mode=1 → o_Round=0 key 0xCB3D8B0E17F5; o_Round=15 key 0x1B02EFFC7072; the full sequence is the exact reverse of the encrypt sequence.
- Backpressure: hold i_Key_Ready=0 for 5 cycles at round 3 → key and index stable; total run length extends by exactly 5 cycles.
- Parity: i_Key=0x123457799BBCDFF1 (byte 0x12 has even parity) → o_Parity_Err=1 and keys still generated; next start with 0x133457799BBCDFF1 → o_Parity_Err=0.
- Abort/ignore: i_Start while o_Busy is ignored; i_Abort at round 7 coincident with a handshake → IDLE next cycle, no o_Done, o_Key_Valid=0.
- Reset/reduced rounds: assert i_Rst mid-run → all outputs 0 asynchronously. With ROUNDS=4, only rounds 0..3 are emitted, then o_Done.
